vector_alu_seq: RTL and testbench

//  Lane-serial vector ALU downstream of the 4-entry 512-bit vector register file.

---
 rtl/vector_alu_if.sv | 24 ++
 rtl/vector_alu_seq.sv | 122 ++++++++++++
 tb/tb_vector_alu_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_alu_if.sv
// Operand/result bundle between the control unit, the vector ALU and the register file.
// The master side issues start/op/a/b; the slave side (the ALU) returns busy/done/results.
interface vector_alu_if #(
    parameter int N = 512
) ();
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result_lo;
    logic [N-1:0] result_hi;

    modport master (
        output start, op, a, b,
        input  busy, done, result_lo, result_hi
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_lo, result_hi
    );
endinterface

// File: rtl/vector_alu_seq.sv
// Lane-serial vector ALU: add/sub/umul/smul over W-bit lanes, LPC lanes per clock,
// C = N/(W*LPC) chunks per operation, followed by a one-cycle done pulse.
module vector_alu_seq #(
    parameter int N   = 512,
    parameter int W   = 32,
    parameter int LPC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    vector_alu_if.slave bus
);

    localparam int C  = N / (W * LPC);
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_UMUL = 2'b10, OP_SMUL = 2'b11} op_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           accept;
    op_t            op_q;
    logic [N-1:0]   a_q, b_q;
    logic [N-1:0]   lo_q, hi_q;
    int             lane_base;
    logic [2*W-1:0] chunk_res [LPC];

    // One lane's {hi, lo}; add/sub put the carry/borrow in bit 0 of hi.
    function automatic logic [2*W-1:0] lane_op(op_t op, logic [W-1:0] x, logic [W-1:0] y);
        logic [W:0]     ext;
        logic [2*W-1:0] r;
        ext = '0;
        r   = '0;
        unique case (op)
            OP_ADD: begin
                ext = {1'b0, x} + {1'b0, y};
                r   = {{(W-1){1'b0}}, ext};
            end
            OP_SUB: begin
                ext = {1'b0, x} - {1'b0, y};
                r   = {{(W-1){1'b0}}, ext};
            end
            OP_UMUL: r = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            OP_SMUL: r = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
        endcase
        return r;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(C - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        lane_base = int'(cnt_q) * LPC;
        for (int l = 0; l < LPC; l++) begin
            chunk_res[l] = lane_op(op_q, a_q[(lane_base + l) * W +: W], b_q[(lane_base + l) * W +: W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand and result registers are plain flops, not RAM, so they take the async reset.
        if (!rst_n) begin
            op_q <= OP_ADD;
            a_q  <= '0;
            b_q  <= '0;
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            if (accept) begin
                op_q <= op_t'(bus.op);
                a_q  <= bus.a;
                b_q  <= bus.b;
            end
            // Lanes not in the current chunk keep their previous result.
            if (state_q == RUN) begin
                for (int l = 0; l < LPC; l++) begin
                    lo_q[(lane_base + l) * W +: W] <= chunk_res[l][W-1:0];
                    hi_q[(lane_base + l) * W +: W] <= chunk_res[l][2*W-1:W];
                end
            end
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result_lo = lo_q;
    assign bus.result_hi = hi_q;

endmodule

// File: tb/tb_vector_alu_seq.sv
// Randomized self-checking bench for vector_alu_seq against a lane-by-lane arithmetic model.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_vector_alu_seq;

    localparam int N     = 512;
    localparam int W     = 32;
    localparam int LPC   = 4;
    localparam int C     = N / (W * LPC);
    localparam int LANES = N / W;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [N-1:0] prev_lo, prev_hi;

    vector_alu_if #(.N(N)) bus ();

    vector_alu_seq #(.N(N), .W(W), .LPC(LPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: per-lane result from 64-bit arithmetic.
    function automatic void model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] lo, output logic [N-1:0] hi);
        logic [31:0] x, y;
        logic [63:0] p;
        lo = '0;
        hi = '0;
        for (int i = 0; i < LANES; i++) begin
            x = a[i*W +: W];
            y = b[i*W +: W];
            case (op)
                2'd0: p = {32'd0, x} + {32'd0, y};
                2'd1: p = {31'd0, (x < y), x - y};
                2'd2: p = {32'd0, x} * {32'd0, y};
                default: p = longint'($signed(x)) * longint'($signed(y));
            endcase
            lo[i*W +: W] = p[31:0];
            hi[i*W +: W] = p[63:32];
        end
    endfunction

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] v;
        logic [31:0]  corner [5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(0, 3) == 0) v[i*W +: W] = corner[$urandom_range(0, 4)];
            else                           v[i*W +: W] = $urandom;
        end
        return v;
    endfunction

    function automatic logic [N-1:0] fill_lanes(input logic [31:0] val);
        logic [N-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*W +: W] = val;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one unit after an edge with the DUT idle or in its done cycle; returns in the done cycle.
    task automatic run_op(input string tag, input logic [1:0] op_v, input logic [N-1:0] a_v,
                          input logic [N-1:0] b_v);
        logic [N-1:0] exp_lo, exp_hi, part_lo, part_hi;
        model(op_v, a_v, b_v, exp_lo, exp_hi);
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.a     = a_v;
        bus.b     = b_v;
        tick();
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = rand_vec();
        bus.b     = rand_vec();
        for (int k = 1; k <= C + 1; k++) begin
            if (k > 1) tick();
            part_lo = prev_lo;
            part_hi = prev_hi;
            for (int i = 0; i < (k - 1) * LPC; i++) begin
                part_lo[i*W +: W] = exp_lo[i*W +: W];
                part_hi[i*W +: W] = exp_hi[i*W +: W];
            end
            check({tag, "_busy"}, N'(bus.busy), N'(k <= C));
            check({tag, "_done"}, N'(bus.done), N'(k == C + 1));
            check({tag, "_lo"}, bus.result_lo, part_lo);
            check({tag, "_hi"}, bus.result_hi, part_hi);
        end
        prev_lo = exp_lo;
        prev_hi = exp_hi;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, N'(bus.busy), '0);
        check({tag, "_done"}, N'(bus.done), '0);
    endtask

    initial begin
        logic [N-1:0] a_v, b_v, a_cur, a_second, e1_lo, e1_hi, e2_lo, e2_hi;
        logic [1:0]   op_v;
        vectors     = 0;
        miscompares = 0;
        prev_lo     = '0;
        prev_hi     = '0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.a       = '0;
        bus.b       = '0;

        repeat (2) tick();
        check_idle("reset");
        check("reset_lo", bus.result_lo, '0);
        check("reset_hi", bus.result_hi, '0);
        rst_n = 1'b1;
        tick();

        run_op("t1_add", 2'd0, fill_lanes(32'hFFFF_FFFF), fill_lanes(32'd1));
        check("t1_lo_zero", bus.result_lo, '0);
        check("t1_hi_one", bus.result_hi, fill_lanes(32'd1));

        a_v = '0; b_v = '0;
        a_v[31:0] = 32'd5;
        b_v[31:0] = 32'd7;
        run_op("t2_sub", 2'd1, a_v, b_v);
        check("t2_lo0", N'(bus.result_lo[31:0]), N'(32'hFFFF_FFFE));
        check("t2_hi0", N'(bus.result_hi[31:0]), N'(32'd1));

        run_op("t3_umul", 2'd2, fill_lanes(32'hFFFF_FFFF), fill_lanes(32'hFFFF_FFFF));
        check("t3_lo", bus.result_lo, fill_lanes(32'h0000_0001));
        check("t3_hi", bus.result_hi, fill_lanes(32'hFFFF_FFFE));

        for (int i = 0; i < LANES; i++) begin
            a_v[i*W +: W] = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
            b_v[i*W +: W] = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'd3;
        end
        run_op("t4_smul", 2'd3, a_v, b_v);
        check("t4_lo_m1m1", N'(bus.result_lo[31:0]), N'(32'd1));
        check("t4_hi_m1m1", N'(bus.result_hi[31:0]), N'(32'd0));
        check("t4_lo_m2p3", N'(bus.result_lo[63:32]), N'(32'hFFFF_FFFA));
        check("t4_hi_m2p3", N'(bus.result_hi[63:32]), N'(32'hFFFF_FFFF));

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                tick();
                check_idle("rand_gap");
            end
            run_op("rand", 2'($urandom_range(0, 3)), rand_vec(), rand_vec());
        end

        // Start held high for ten cycles with a fresh A every cycle.
        tick();
        check_idle("t5_pre");
        op_v  = 2'd2;
        b_v   = rand_vec();
        a_cur = rand_vec();
        model(op_v, a_cur, b_v, e1_lo, e1_hi);
        a_second  = '0;
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.b     = b_v;
        bus.a     = a_cur;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("t5_busy", N'(bus.busy), N'(!(k == 5 || k == 10)));
            check("t5_done", N'(bus.done), N'(k == 5 || k == 10));
            if (k == 5) begin
                check("t5_first_lo", bus.result_lo, e1_lo);
                check("t5_first_hi", bus.result_hi, e1_hi);
            end
            if (k == 10) begin
                model(op_v, a_second, b_v, e2_lo, e2_hi);
                check("t5_second_lo", bus.result_lo, e2_lo);
                check("t5_second_hi", bus.result_hi, e2_hi);
                bus.start = 1'b0;
            end else begin
                a_cur = rand_vec();
                bus.a = a_cur;
                if (k == 5) a_second = a_cur;
            end
        end
        tick();
        check_idle("t5_post");
        prev_lo = e2_lo;
        prev_hi = e2_hi;

        // Reset two cycles into an operation.
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.a     = rand_vec();
        bus.b     = rand_vec();
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_idle("t6_rst");
        check("t6_rst_lo", bus.result_lo, '0);
        check("t6_rst_hi", bus.result_hi, '0);
        tick();
        rst_n = 1'b1;
        prev_lo = '0;
        prev_hi = '0;
        for (int k = 0; k < C + 2; k++) begin
            tick();
            check_idle("t6_after");
        end
        run_op("t6_fresh", 2'd3, rand_vec(), rand_vec());
        tick();
        check_idle("t6_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
